// File: rtl/trivium_stream_pkg.sv
// Shared fetch-state type and block/word sizing for the Trivium keystream XOR stage.
package trivium_stream_pkg;

  localparam int KS_W_DEF      = 64;
  localparam int DATA_W_DEF    = 8;
  localparam int WORDS_PER_BLK = KS_W_DEF / DATA_W_DEF;

  // A one-word block would still need a 1-bit index register.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int IDX_W = idx_width(WORDS_PER_BLK);

  typedef enum logic [1:0] {
    F_WAIT_HI = 2'd0,
    F_REQ     = 2'd1,
    F_WAIT_LO = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/trivium_stream_xor_ks_fetch.sv
// Keystream fetch FSM: captures a block when one is offered and the buffer is free, then requests the next.
module ks_fetch
  import trivium_stream_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ks_ready,
  input  logic buf_free,
  output logic ks_next,
  output logic capture
);

  fetch_state_t state, state_nxt;

  // Waiting for ks_ready to fall before re-arming keeps a stale block from being captured twice.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      F_WAIT_HI: begin
        if (ks_ready && buf_free) begin
          capture   = 1'b1;
          state_nxt = F_REQ;
        end
      end
      F_REQ:     state_nxt = F_WAIT_LO;
      F_WAIT_LO: if (!ks_ready) state_nxt = F_WAIT_HI;
      default:   state_nxt = F_WAIT_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= F_WAIT_HI;
    else     state <= state_nxt;
  end

  assign ks_next = (state == F_REQ);

endmodule

// File: rtl/trivium_stream_xor.sv
// Trivium keystream consumer: buffers one block and XORs a valid/ready word stream with it, MSB word first.
// Defining STREAM_XOR_CNT_EN adds word_cnt, a wrapping count of output words accepted downstream.
module trivium_stream_xor
  import trivium_stream_pkg::*;
#(
  parameter int KS_W   = KS_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KS_W-1:0]   ks_block,
  input  logic              ks_ready,
  output logic              ks_next,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef STREAM_XOR_CNT_EN
  ,
  output logic [31:0]       word_cnt
`endif
);

  localparam int WORDS = KS_W / DATA_W;
  localparam int IW    = idx_width(WORDS);

  if (KS_W % DATA_W != 0) begin : g_width_check
    $error("trivium_stream_xor: KS_W must be an integer multiple of DATA_W");
  end

  logic [KS_W-1:0]   ks_buf;
  logic [KS_W-1:0]   ks_shifted;
  logic [DATA_W-1:0] ks_slice;
  logic [IW-1:0]     word_idx;
  logic              buf_valid;
  logic              accept;
  logic              last_word;
  logic              buf_free;
  logic              capture;

  assign s_ready   = buf_valid && (!m_valid || m_ready);
  assign accept    = s_valid && s_ready;
  assign last_word = (word_idx == IW'(WORDS - 1));
  assign buf_free  = !buf_valid || (accept && last_word);

  // Shifting the wanted word up to the MSB end selects word k = ks_buf[KS_W-1-k*DATA_W -: DATA_W].
  assign ks_shifted = ks_buf << (int'(word_idx) * DATA_W);
  assign ks_slice   = ks_shifted[KS_W-1 -: DATA_W];

  ks_fetch u_fetch (
    .clk      (clk),
    .rst      (rst),
    .ks_ready (ks_ready),
    .buf_free (buf_free),
    .ks_next  (ks_next),
    .capture  (capture)
  );

  // A refill in the same cycle as the last word wins over the wrap, so blocks stream without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ks_buf    <= '0;
      buf_valid <= 1'b0;
      word_idx  <= '0;
    end else if (capture) begin
      ks_buf    <= ks_block;
      buf_valid <= 1'b1;
      word_idx  <= '0;
    end else if (accept) begin
      if (last_word) begin
        buf_valid <= 1'b0;
        word_idx  <= '0;
      end else begin
        word_idx <= word_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
    end else if (accept) begin
      m_data  <= s_data ^ ks_slice;
      m_valid <= 1'b1;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef STREAM_XOR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                    word_cnt <= '0;
    else if (m_valid && m_ready) word_cnt <= word_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_trivium_stream_xor.sv
// Scoreboard bench for trivium_stream_xor with a simple trivium_wrapper handshake model.
module tb_trivium_stream_xor;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ks_block;
  logic        ks_ready;
  logic        ks_next;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
`ifdef STREAM_XOR_CNT_EN
  logic [31:0] word_cnt;
`endif

  int n_checks    = 0;
  int n_fail      = 0;
  int cyc         = 0;
  int ks_next_cnt = 0;
  int hold_cycles = 0;
  int wm_hold     = -1;

  logic [63:0] blk_q[$];
  logic [7:0]  exp_q[$];
  int          acc_time[$];
  logic [7:0]  exp_cur;
  logic [7:0]  t1_exp [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  trivium_stream_xor dut (
    .clk      (clk),
    .rst      (rst),
    .ks_block (ks_block),
    .ks_ready (ks_ready),
    .ks_next  (ks_next),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
`ifdef STREAM_XOR_CNT_EN
    ,
    .word_cnt (word_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Realign to just after a rising edge before driving new stimulus.
  task automatic syncDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [7:0] e);
    int waited;
    waited  = 0;
    s_data  = d;
    exp_cur = e;
    s_valid = 1'b1;
    @(negedge clk);
    while (s_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (s_ready !== 1'b1) failNow("accept timeout s_ready", {63'd0, s_ready}, 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic sendBlock(input logic [63:0] blk, input logic [7:0] base, input int first, input int last);
    logic [63:0] sh;
    logic [7:0]  d;
    for (int i = first; i <= last; i++) begin
      sh = blk >> (56 - 8 * i);
      d  = base + 8'(i);
      applyStimulus(d, d ^ sh[7:0]);
    end
  endtask

  // Wrapper model: offer a queued block, drop ks_ready hold_cycles after seeing ks_next.
  initial begin
    ks_ready = 1'b0;
    ks_block = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        ks_ready = 1'b0;
        wm_hold  = -1;
      end else if (!ks_ready) begin
        if (blk_q.size() > 0) begin
          ks_block = blk_q.pop_front();
          ks_ready = 1'b1;
        end
      end else if (wm_hold >= 0) begin
        if (wm_hold == 0) begin
          ks_ready = 1'b0;
          wm_hold  = -1;
        end else begin
          wm_hold--;
        end
      end else if (ks_next === 1'b1) begin
        wm_hold = hold_cycles;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (s_valid === 1'b1 && s_ready === 1'b1) begin
      exp_q.push_back(exp_cur);
      acc_time.push_back(cyc);
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) failNow("unexpected output m_data", {56'd0, m_data}, 64'd0);
      else checkOutput("scoreboard m_data", {56'd0, m_data}, {56'd0, exp_q.pop_front()});
    end
  end

  initial forever begin
    @(negedge clk);
    if (ks_next === 1'b1) ks_next_cnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int rise_cyc;
    int rdy_cyc;
    int w;
    int hi_cnt;

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    exp_cur = '0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset ks_next", {63'd0, ks_next}, 64'd0);
    checkOutput("reset s_ready", {63'd0, s_ready}, 64'd0);
    checkOutput("reset m_valid", {63'd0, m_valid}, 64'd0);
    checkOutput("reset m_data", {56'd0, m_data}, 64'd0);
`ifdef STREAM_XOR_CNT_EN
    checkOutput("reset word_cnt", {32'd0, word_cnt}, 64'd0);
`endif
    syncDrive();
    rst = 1'b0;

    $display("[TB] block load and MSB-first order");
    blk_q.push_back(64'h0123456789ABCDEF);
    for (int i = 0; i < 8; i++) applyStimulus(8'h00, t1_exp[i]);
    repeat (4) @(negedge clk);
    checkOutput("ks_next pulses after first block", 64'(ks_next_cnt), 64'd1);

    $display("[TB] xor correctness and latency");
    syncDrive();
    blk_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(8'h5A, 8'hA5);
    @(negedge clk);
    checkOutput("latency m_valid", {63'd0, m_valid}, 64'd1);
    checkOutput("latency m_data", {56'd0, m_data}, 64'hA5);
    syncDrive();
    sendBlock(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1, 7);

    $display("[TB] back-to-back blocks");
    blk_q.push_back(64'hA0A1A2A3A4A5A6A7);
    blk_q.push_back(64'h1111111111111111);
    base = acc_time.size();
    sendBlock(64'hA0A1A2A3A4A5A6A7, 8'h20, 0, 7);
    sendBlock(64'h1111111111111111, 8'h30, 0, 7);
    checkOutput("back-to-back accept span", 64'(acc_time[base + 15] - acc_time[base]), 64'd15);

    $display("[TB] starved keystream");
    blk_q.push_back(64'h0F1E2D3C4B5A6978);
    sendBlock(64'h0F1E2D3C4B5A6978, 8'h40, 0, 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("starved s_ready", {63'd0, s_ready}, 64'd0);
    end
    hold_cycles = 12;
    blk_q.push_back(64'hC3C3C3C3C3C3C3C3);
    w = 0;
    @(negedge clk);
    while (ks_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    rise_cyc = cyc;
    w = 0;
    while (s_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    rdy_cyc = cyc;
    checkOutput("capture one cycle after ks_ready rise", 64'(rdy_cyc - rise_cyc), 64'd1);
    syncDrive();
    sendBlock(64'hC3C3C3C3C3C3C3C3, 8'h50, 0, 7);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_ready === 1'b1) hi_cnt++;
    end
    checkOutput("no duplicate capture s_ready cycles", 64'(hi_cnt), 64'd0);
    checkOutput("ks_next pulses after starved test", 64'(ks_next_cnt), 64'd6);
    hold_cycles = 0;

    $display("[TB] backpressure");
    syncDrive();
    blk_q.push_back(64'h8877665544332211);
    sendBlock(64'h8877665544332211, 8'h60, 0, 2);
    m_ready = 1'b0;
    s_data  = 8'h63;
    exp_cur = 8'h63 ^ 8'h55;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall m_valid", {63'd0, m_valid}, 64'd1);
      checkOutput("stall m_data", {56'd0, m_data}, 64'h04);
      checkOutput("stall s_ready", {63'd0, s_ready}, 64'd0);
    end
    syncDrive();
    m_ready = 1'b1;
    sendBlock(64'h8877665544332211, 8'h60, 3, 7);

    $display("[TB] reset mid-block");
    blk_q.push_back(64'h2468ACE013579BDF);
    sendBlock(64'h2468ACE013579BDF, 8'h70, 0, 2);
    rst = 1'b1;
    syncDrive();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset m_valid", {63'd0, m_valid}, 64'd0);
    checkOutput("post-reset ks_next", {63'd0, ks_next}, 64'd0);
    checkOutput("post-reset s_ready", {63'd0, s_ready}, 64'd0);
    checkOutput("post-reset pending outputs", 64'(exp_q.size()), 64'd0);
`ifdef STREAM_XOR_CNT_EN
    checkOutput("post-reset word_cnt", {32'd0, word_cnt}, 64'd0);
`endif
    syncDrive();
    blk_q.push_back(64'h5566778899AABBCC);
    sendBlock(64'h5566778899AABBCC, 8'h80, 0, 7);
    repeat (3) @(negedge clk);
    checkOutput("final pending outputs", 64'(exp_q.size()), 64'd0);
    checkOutput("final ks_next pulses", 64'(ks_next_cnt), 64'd9);
`ifdef STREAM_XOR_CNT_EN
    checkOutput("final word_cnt", {32'd0, word_cnt}, 64'd8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
